// File: rtl/forward_ctrl_pkg.sv
// Shared pipeline types for the forwarding/hazard controller: forward-select
// encoding decoded by the EX operand muxes, register address type, PC index.
package pipe_pkg;

  localparam int NREG_BITS = 4;
  localparam int PC_REG    = 15;
  localparam int CNT_W     = 16;

  typedef logic [NREG_BITS-1:0] reg_addr_t;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_EXM = 2'b10
  } fwd_sel_t;

endpackage

// File: rtl/forward_ctrl_if.sv
// ID-stage hazard inputs and EX forward / stall / flush controls between the
// pipeline datapath (master) and forward_ctrl (slave).
interface forward_ctrl_if
  import pipe_pkg::*;
#(
  parameter int NREG_BITS = 4,
  parameter int CNT_W     = 16
) ();

  logic [NREG_BITS-1:0] RA1_D;
  logic [NREG_BITS-1:0] RA2_D;
  logic [NREG_BITS-1:0] WA_D;
  logic                 Use1_D;
  logic                 Use2_D;
  logic                 RegWrite_D;
  logic                 MemToReg_D;
  logic                 BranchTaken_E;
  fwd_sel_t             ForwardA;
  fwd_sel_t             ForwardB;
  logic                 StallF;
  logic                 StallD;
  logic                 FlushD;
  logic                 FlushE;
  logic [CNT_W-1:0]     StallCount;

  modport master (
    output RA1_D, RA2_D, WA_D, Use1_D, Use2_D, RegWrite_D, MemToReg_D, BranchTaken_E,
    input  ForwardA, ForwardB, StallF, StallD, FlushD, FlushE, StallCount
  );

  modport slave (
    input  RA1_D, RA2_D, WA_D, Use1_D, Use2_D, RegWrite_D, MemToReg_D, BranchTaken_E,
    output ForwardA, ForwardB, StallF, StallD, FlushD, FlushE, StallCount
  );

endinterface

// File: rtl/forward_ctrl_fwd_select.sv
// One operand's next forward select: the younger producer (now in EX, next in
// MEM) wins over the older one (now in MEM, next in WB); the PC is never forwarded.
module fwd_select
  import pipe_pkg::*;
#(
  parameter int NREG_BITS = 4,
  parameter int PC_REG    = 15
) (
  input  logic [NREG_BITS-1:0] ra_i,
  input  logic                 use_i,
  input  logic [NREG_BITS-1:0] wa_e_i,
  input  logic                 regwrite_e_i,
  input  logic [NREG_BITS-1:0] wa_m_i,
  input  logic                 regwrite_m_i,
  output fwd_sel_t             sel_o
);

  localparam logic [NREG_BITS-1:0] PC_ADDR = NREG_BITS'(PC_REG);

  logic eligible_s;

  // Priority select: EX/MEM match before MEM/WB match.
  always_comb begin
    eligible_s = use_i && (ra_i != PC_ADDR);
    if (eligible_s && regwrite_e_i && (wa_e_i == ra_i)) begin
      sel_o = FWD_EXM;
    end else if (eligible_s && regwrite_m_i && (wa_m_i == ra_i)) begin
      sel_o = FWD_WB;
    end else begin
      sel_o = FWD_REG;
    end
  end

endmodule

// File: rtl/forward_ctrl.sv
// Forwarding and load-use hazard controller: shadows destination info through
// E and M, registers the EX forward selects and drives stall/flush controls.
module forward_ctrl
  import pipe_pkg::*;
#(
  parameter int NREG_BITS = 4,
  parameter int PC_REG    = 15,
  parameter int CNT_W     = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  forward_ctrl_if.slave bus
);

  // Only the fields that the hazard and forward logic consume are shadowed.
  logic [NREG_BITS-1:0] wa_e_q;
  logic                 regwrite_e_q;
  logic                 memtoreg_e_q;
  logic [NREG_BITS-1:0] wa_m_q;
  logic                 regwrite_m_q;
  fwd_sel_t             fwd_a_q, fwd_a_d;
  fwd_sel_t             fwd_b_q, fwd_b_d;
  logic [CNT_W-1:0]     stall_count_q;

  fwd_sel_t sel_a_s, sel_b_s;
  logic     load_use_s, stall_s, flush_e_s;

  fwd_select #(.NREG_BITS(NREG_BITS), .PC_REG(PC_REG)) u_fwd_a (
    .ra_i(bus.RA1_D), .use_i(bus.Use1_D),
    .wa_e_i(wa_e_q), .regwrite_e_i(regwrite_e_q),
    .wa_m_i(wa_m_q), .regwrite_m_i(regwrite_m_q),
    .sel_o(sel_a_s)
  );

  fwd_select #(.NREG_BITS(NREG_BITS), .PC_REG(PC_REG)) u_fwd_b (
    .ra_i(bus.RA2_D), .use_i(bus.Use2_D),
    .wa_e_i(wa_e_q), .regwrite_e_i(regwrite_e_q),
    .wa_m_i(wa_m_q), .regwrite_m_i(regwrite_m_q),
    .sel_o(sel_b_s)
  );

  // Hazard detection; a taken branch overrides the load-use stall.
  always_comb begin
    load_use_s = memtoreg_e_q && regwrite_e_q &&
                 ((bus.Use1_D && (wa_e_q == bus.RA1_D)) ||
                  (bus.Use2_D && (wa_e_q == bus.RA2_D)));
    stall_s    = load_use_s && !bus.BranchTaken_E;
    flush_e_s  = load_use_s || bus.BranchTaken_E;
    if (flush_e_s) begin
      fwd_a_d = FWD_REG;
      fwd_b_d = FWD_REG;
    end else begin
      fwd_a_d = sel_a_s;
      fwd_b_d = sel_b_s;
    end
  end

  // Stage advance, registered selects and saturating stall counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wa_e_q        <= '0;
      regwrite_e_q  <= 1'b0;
      memtoreg_e_q  <= 1'b0;
      wa_m_q        <= '0;
      regwrite_m_q  <= 1'b0;
      fwd_a_q       <= FWD_REG;
      fwd_b_q       <= FWD_REG;
      stall_count_q <= '0;
    end else begin
      if (flush_e_s) begin
        wa_e_q       <= '0;
        regwrite_e_q <= 1'b0;
        memtoreg_e_q <= 1'b0;
      end else begin
        wa_e_q       <= bus.WA_D;
        regwrite_e_q <= bus.RegWrite_D;
        memtoreg_e_q <= bus.MemToReg_D;
      end
      wa_m_q       <= wa_e_q;
      regwrite_m_q <= regwrite_e_q;
      fwd_a_q      <= fwd_a_d;
      fwd_b_q      <= fwd_b_d;
      if (stall_s && (stall_count_q != {CNT_W{1'b1}})) begin
        stall_count_q <= stall_count_q + CNT_W'(1);
      end else begin
        stall_count_q <= stall_count_q;
      end
    end
  end

  assign bus.ForwardA   = fwd_a_q;
  assign bus.ForwardB   = fwd_b_q;
  assign bus.StallF     = stall_s;
  assign bus.StallD     = stall_s;
  assign bus.FlushD     = bus.BranchTaken_E;
  assign bus.FlushE     = flush_e_s;
  assign bus.StallCount = stall_count_q;

endmodule
